// File: rtl/bus_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_src_arbiter
// Purpose  : Registered selector that places one of NUM_CH WIDTH-bit sources
//            on the shared SAP bus. It has two modes. In direct mode, sel
//            picks the channel. In arbitrated mode, requesting channels
//            share the bus round-robin, with a bounded hold.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            in_data    - flattened sources, channel k at [k*WIDTH +: WIDTH]
//            req        - per-channel bus request (arbitrated mode)
//            mode       - 0 = direct select, 1 = round-robin arbitration
//            sel        - channel index used in direct mode
//            out        - registered bus data
//            out_valid  - out carries data from a granted channel
//            grant      - one-hot grant, zero when idle
//            grant_idx  - index of the granted channel, 0 when idle
// Revision : 1.0 - initial release
// ============================================================================
module bus_src_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       req,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    output logic [NUM_CH-1:0]       grant,
    output logic [SEL_W-1:0]        grant_idx
);

    localparam int                  c_HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE = c_HOLD_W'(1);
    localparam logic [SEL_W:0]      c_NUM_CH   = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0]    c_LAST     = SEL_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]   c_ONE      = NUM_CH'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      rr_q, rr_d;
    logic [c_HOLD_W-1:0]   hold_q, hold_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  valid_q, valid_d;
    logic [NUM_CH-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0]      idx_q, idx_d;

    logic                  win_en;
    logic [SEL_W-1:0]      win_idx;

    logic                  w_sel_ok;
    logic [NUM_CH-1:0]     w_g_mask;
    logic                  w_own_req;
    logic [NUM_CH-1:0]     w_others;
    logic                  w_timeout;
    logic [SEL_W-1:0]      w_next_ptr;
    logic [SEL_W:0]        w_idle_pick;
    logic [SEL_W:0]        w_hand_pick;

    // Data of the channel with index idx. An index out of range reads as zero.
    function automatic logic [WIDTH-1:0] f_chan_data(input logic [NUM_CH*WIDTH-1:0] d,
                                                     input logic [SEL_W-1:0]        idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == SEL_W'(k)) v = d[k*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    // First set bit of r when scanning upward from start and wrapping.
    // The result is {found, index}. The scan splits into two ranges:
    // [start, NUM_CH) and [0, start). The lowest hit in the upper range
    // wins. This avoids any modulo arithmetic on non-power-of-two NUM_CH.
    function automatic logic [SEL_W:0] f_rr_pick(input logic [NUM_CH-1:0] r,
                                                 input logic [SEL_W-1:0]  start);
        logic             hi_found, lo_found;
        logic [SEL_W-1:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r[k]) begin
                if (k >= int'(start)) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = SEL_W'(k);
                end
            end
        end
        return hi_found ? {1'b1, hi_idx} : {lo_found, lo_idx};
    endfunction

    assign w_sel_ok    = ({1'b0, sel} < c_NUM_CH);
    assign w_g_mask    = c_ONE << idx_q;
    assign w_own_req   = |(req & w_g_mask);
    // The current holder is always excluded from the handover scan. On a
    // request-drop release it is not requesting anyway. On a timeout it must
    // not win again.
    assign w_others    = req & ~w_g_mask;
    assign w_timeout   = (hold_q == c_HOLD_MAX) && (|w_others);
    assign w_next_ptr  = (idx_q == c_LAST) ? '0 : idx_q + SEL_W'(1);
    assign w_idle_pick = f_rr_pick(req, rr_q);
    assign w_hand_pick = f_rr_pick(w_others, w_next_ptr);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        win_en  = 1'b0;
        win_idx = '0;

        if (!mode) begin
            // A direct-mode edge abandons any grant. The pointer is kept.
            state_d = ST_IDLE;
            hold_d  = '0;
            win_en  = w_sel_ok;
            win_idx = sel;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_idle_pick[SEL_W]) begin
                        win_en  = 1'b1;
                        win_idx = w_idle_pick[SEL_W-1:0];
                        hold_d  = c_HOLD_ONE;
                        state_d = ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (w_own_req && !w_timeout) begin
                        win_en  = 1'b1;
                        win_idx = idx_q;
                        if (hold_q != c_HOLD_MAX) hold_d = hold_q + c_HOLD_W'(1);
                    end else begin
                        // Release. Hand over on the same edge if anyone else waits.
                        rr_d = w_next_ptr;
                        if (w_hand_pick[SEL_W]) begin
                            win_en  = 1'b1;
                            win_idx = w_hand_pick[SEL_W-1:0];
                            hold_d  = c_HOLD_ONE;
                        end else begin
                            hold_d  = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        out_d   = '0;
        valid_d = 1'b0;
        grant_d = '0;
        idx_d   = '0;
        if (win_en) begin
            out_d   = f_chan_data(in_data, win_idx);
            valid_d = 1'b1;
            grant_d = c_ONE << win_idx;
            idx_d   = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign grant     = grant_q;
    assign grant_idx = idx_q;

endmodule
`default_nettype wire
